// File: rtl/ray_fifo_arbiter_pkg.sv
// Shared types and default sizing for the ray FIFO arbiter.
package ray_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/ray_fifo_arbiter_rr_pick.sv
// Round-robin search: first set bit of req at or after start, wrapping at NUM_REQ-1.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int k;
        logic [ID_W-1:0] kk;
        found = 1'b0;
        idx   = '0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(start) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            kk = ID_W'(k);
            if (!found && req[kk]) begin
                found = 1'b1;
                idx   = kk;
            end
        end
    end

endmodule

// File: rtl/ray_fifo_arbiter.sv
// Burst round-robin arbiter feeding one registered vector stage into a fifo_array.
module ray_fifo_arbiter
    import ray_arb_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int ARRAY_SIZE      = 3,
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int BURST_LEN       = DEF_BURST_LEN
) (
    input  logic                                                     clock,
    input  logic                                                     reset,
    input  logic                                                     flush,
    input  logic [NUM_REQ-1:0]                                       req_valid,
    input  logic signed [NUM_REQ-1:0][ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                                       req_ready,
    input  logic                                                     fifo_full,
    output logic                                                     fifo_wr_en,
    output logic signed [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0]        fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]                               grant_id,
    output logic                                                     busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic             out_valid;

    logic             ready_int;
    logic             hold;
    logic             release_now;
    logic             accept;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_start;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [ID_W-1:0]  sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner keeps the grant while it has data and burst budget; otherwise the
    // search restarts just past it so the release and the new grant share a cycle.
    always_comb begin
        ready_int   = !out_valid || !fifo_full;
        next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        hold        = (state == BURST) && req_valid[grant_id] && (cnt < CNT_MAX);
        release_now = (state == BURST) && !hold;
        pick_start  = release_now ? next_ptr : rr_ptr;
        sel         = hold ? grant_id : pick_idx;
        accept      = ready_int && !flush && !reset && (hold || pick_found);
        req_ready   = accept ? (NUM_REQ'(1) << sel) : '0;
        fifo_wr_en  = out_valid && !fifo_full && !reset;
        busy        = !reset && ((state == BURST) || out_valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            fifo_din  <= '0;
            grant_id  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                fifo_din  <= req_data[sel];
            end else if (fifo_wr_en) begin
                out_valid <= 1'b0;
            end

            if (hold) begin
                if (accept) cnt <= cnt + 1'b1;
            end else begin
                if (release_now) rr_ptr <= next_ptr;
                if (accept) begin
                    state    <= BURST;
                    cnt      <= CNT_W'(1);
                    grant_id <= pick_idx;
                end else begin
                    state    <= IDLE;
                    cnt      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ray_fifo_arbiter.sv
// Directed bench for ray_fifo_arbiter with hand-computed cycle tables.
module tb_ray_fifo_arbiter;

    logic                         clock;
    logic                         reset;
    logic                         flush;
    logic [3:0]                   req_valid;
    logic signed [3:0][2:0][31:0] req_data;
    logic [3:0]                   req_ready;
    logic                         fifo_full;
    logic                         fifo_wr_en;
    logic signed [2:0][31:0]      fifo_din;
    logic [1:0]                   grant_id;
    logic                         busy;

    int checks = 0;
    int errors = 0;

    ray_fifo_arbiter #(
        .FIFO_DATA_WIDTH (32),
        .ARRAY_SIZE      (3),
        .NUM_REQ         (4),
        .BURST_LEN       (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic rst_pulse();
        reset     = 1'b1;
        flush     = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [95:0] mkvec(input int v);
        return {32'(-v), 32'(v + 1), 32'(v)};
    endfunction

    function automatic int own_val(input int owner);
        return 16 * (owner + 1);
    endfunction

    int         t2_own [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
    logic [3:0] t4_rdy [11] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h4, 4'h4};
    logic       t4_wr  [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic       t4_full[11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int         t4_d1  [11] = '{1, 2, 3, 3, 3, 3, 3, 3, 4, 5, 5};
    int         t4_out [11] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4, 512};
    logic [3:0] t5_vld [6]  = '{4'h6, 4'h6, 4'h4, 4'h4, 4'hB, 4'hB};
    logic       t5_fl  [6]  = '{0, 0, 0, 1, 0, 0};
    logic [3:0] t5_rdy [6]  = '{4'h2, 4'h2, 4'h4, 4'h0, 4'h8, 4'h8};
    logic       t5_wr  [6]  = '{0, 1, 1, 1, 0, 1};
    logic       t5_busy[6]  = '{0, 1, 1, 1, 0, 1};
    logic [1:0] t5_gnt [6]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        fifo_full = 1'b0;
        req_valid = 4'hF;
        for (int r = 0; r < 4; r++) req_data[r] = mkvec(7);

        // Reset state, with every requester asking
        cyc();
        cyc();
        #1;
        chk("rst_ready", 96'(req_ready), 96'(0));
        chk("rst_wr_en", 96'(fifo_wr_en), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_grant", 96'(grant_id), 96'(0));
        chk("rst_din", 96'(fifo_din), 96'(0));
        reset     = 1'b0;
        req_valid = '0;
        cyc();

        // Requesters 0 and 2 streaming: bursts of four, alternating
        req_valid   = 4'b0101;
        req_data[0] = mkvec(own_val(0));
        req_data[2] = mkvec(own_val(2));
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("rr_ready", 96'(req_ready), 96'(4'(1 << t2_own[i])));
            chk("rr_wr_en", 96'(fifo_wr_en), 96'(i > 0));
            if (i > 0) begin
                chk("rr_grant", 96'(grant_id), 96'(t2_own[i-1]));
                chk("rr_din", 96'(fifo_din), mkvec(own_val(t2_own[i-1])));
            end
            cyc();
        end

        // Lone requester 3, ten beats 1..10, re-granted across burst boundaries
        rst_pulse();
        for (int i = 0; i <= 10; i++) begin
            req_valid   = (i < 10) ? 4'b1000 : 4'b0000;
            req_data[3] = mkvec(i + 1);
            #1;
            if (i < 10) chk("solo_ready", 96'(req_ready), 96'(4'b1000));
            if (i > 0) begin
                chk("solo_din", 96'(fifo_din), mkvec(i));
                chk("solo_wr_en", 96'(fifo_wr_en), 96'(1));
                chk("solo_grant", 96'(grant_id), 96'(3));
            end
            cyc();
        end

        // Five-cycle fifo_full stall in the middle of requester 1's burst
        rst_pulse();
        req_valid   = 4'b0110;
        req_data[2] = mkvec(512);
        for (int c = 0; c <= 10; c++) begin
            fifo_full   = t4_full[c];
            req_data[1] = mkvec(t4_d1[c]);
            #1;
            chk("stall_ready", 96'(req_ready), 96'(t4_rdy[c]));
            chk("stall_wr_en", 96'(fifo_wr_en), 96'(t4_wr[c]));
            if (c > 0) chk("stall_din", 96'(fifo_din), mkvec(t4_out[c]));
            if (c == 10) chk("stall_grant", 96'(grant_id), 96'(2));
            cyc();
        end

        // Early release to requester 2, then flush, then resume from preserved pointer
        rst_pulse();
        req_data[0] = mkvec(50);
        req_data[1] = mkvec(100);
        req_data[2] = mkvec(200);
        req_data[3] = mkvec(300);
        for (int c = 0; c < 6; c++) begin
            req_valid = t5_vld[c];
            flush     = t5_fl[c];
            #1;
            chk("drop_ready", 96'(req_ready), 96'(t5_rdy[c]));
            chk("drop_wr_en", 96'(fifo_wr_en), 96'(t5_wr[c]));
            chk("drop_busy", 96'(busy), 96'(t5_busy[c]));
            chk("drop_grant", 96'(grant_id), 96'(t5_gnt[c]));
            if (c == 2) chk("drop_din2", 96'(fifo_din), mkvec(100));
            if (c == 5) chk("drop_din5", 96'(fifo_din), mkvec(300));
            cyc();
        end
        flush = 1'b0;

        // Reset on the third beat of requester 3's burst
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 96'(req_ready), 96'(0));
        chk("mid_rst_wr_en", 96'(fifo_wr_en), 96'(0));
        chk("mid_rst_busy", 96'(busy), 96'(0));
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_din", 96'(fifo_din), 96'(0));
        chk("post_rst_grant", 96'(grant_id), 96'(0));
        chk("post_rst_wr_en", 96'(fifo_wr_en), 96'(0));
        chk("post_rst_busy", 96'(busy), 96'(0));
        chk("post_rst_ready", 96'(req_ready), 96'(4'b0001));
        cyc();
        #1;
        chk("post_rst_grant1", 96'(grant_id), 96'(0));
        chk("post_rst_din1", 96'(fifo_din), mkvec(50));
        chk("post_rst_wr1", 96'(fifo_wr_en), 96'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
